// File: rtl/register_file.sv
// RV32I integer register file: 32 x 32-bit registers x0..x31.
// Two combinational read ports feed the execute stage and one synchronous
// write port takes the writeback result. x0 always reads as zero. An
// asynchronous, active-high reset clears the whole array.
// There is deliberately no write-to-read bypass: a read of the register
// being written returns the old value until the rising edge, and the
// pipeline is expected to do any forwarding it needs.
module register_file (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] reg_write,
    input  logic        write,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic [31:0] reg1,
    output logic [31:0] reg2
);

    // Storage array. Entry 0 is cleared by reset and never written, so it stays zero.
    logic [31:0] regs [32];

    // A write takes effect only when enabled and aimed at a register other than x0.
    logic write_hit;
    assign write_hit = write && (rd != 5'd0);

    // Asynchronous reset clears every entry; otherwise perform the enabled write at the rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (write_hit) begin
            regs[rd] <= reg_write;
        end
    end

    // Read port 1: combinational lookup, with x0 forced to zero independently of the array.
    always_comb begin
        reg1 = '0;
        if (rs1 != 5'd0) begin
            reg1 = regs[rs1];
        end
    end

    // Read port 2: same structure as port 1, fully independent so both may address one register.
    always_comb begin
        reg2 = '0;
        if (rs2 != 5'd0) begin
            reg2 = regs[rs2];
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Self-checking testbench for register_file.
// Expected read-port values are pushed onto a scoreboard queue when the
// stimulus is driven and popped and compared when the outputs are sampled.
module tb_register_file;

    logic        clk;
    logic        rst;
    logic [31:0] reg_write;
    logic        write;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] reg1;
    logic [31:0] reg2;

    typedef struct {
        string       name;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } exp_t;

    exp_t sb[$];

    int assertions = 0;
    int failures   = 0;

    // Reference copy of register contents, updated only from the stimulus side.
    logic [31:0] model [32];

    register_file dut (
        .clk       (clk),
        .rst       (rst),
        .reg_write (reg_write),
        .write     (write),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .reg1      (reg1),
        .reg2      (reg2)
    );

    // Free-running 10-time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record the values both read ports should show at the next sample point.
    task automatic push_expect(input string name, input logic [31:0] e1, input logic [31:0] e2);
        exp_t e;
        e.name = name;
        e.exp1 = e1;
        e.exp2 = e2;
        sb.push_back(e);
    endtask

    // Drive a reset pulse spanning one rising edge, and clear the model.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = '0;
    endtask

    // Power-on reset: outputs read zero during and after reset, and writes during reset are blocked.
    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        write = 1'b1;
        rd = 5'd5;
        reg_write = 32'h1234_5678;
        rs1 = 5'd5;
        rs2 = 5'd1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        push_expect("reset_during", 32'h0, 32'h0);
        e = sb.pop_front();
        assertions += 2;
        if (reg1 !== e.exp1) begin failures++; $display("[TB] FAIL %s reg1 got %h expected %h", e.name, reg1, e.exp1); end
        if (reg2 !== e.exp2) begin failures++; $display("[TB] FAIL %s reg2 got %h expected %h", e.name, reg2, e.exp2); end
        rst = 1'b0;
        write = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        rs1 = 5'd1;
        rs2 = 5'd1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            push_expect("reset_after", 32'h0, 32'h0);
            e = sb.pop_front();
            assertions += 2;
            if (reg1 !== e.exp1) begin failures++; $display("[TB] FAIL %s reg1 got %h expected %h", e.name, reg1, e.exp1); end
            if (reg2 !== e.exp2) begin failures++; $display("[TB] FAIL %s reg2 got %h expected %h", e.name, reg2, e.exp2); end
        end
        rs1 = 5'd5;
        #1;
        push_expect("reset_blocked_write", 32'h0, 32'h0);
        e = sb.pop_front();
        assertions++;
        if (reg1 !== e.exp1) begin failures++; $display("[TB] FAIL %s reg1 got %h expected %h", e.name, reg1, e.exp1); end
    endtask

    // Write x1 and read it back on port 1, then on port 2.
    task automatic test_write_ports();
        exp_t e;
        do_reset();
        rd = 5'd1; reg_write = 32'h1; write = 1'b1; rs1 = 5'd1; rs2 = 5'd0;
        model[1] = 32'h1;
        push_expect("write_port1", 32'h1, 32'h0);
        @(posedge clk);
        @(negedge clk);
        write = 1'b0;
        e = sb.pop_front();
        assertions += 2;
        if (reg1 !== e.exp1) begin failures++; $display("[TB] FAIL %s reg1 got %h expected %h", e.name, reg1, e.exp1); end
        if (reg2 !== e.exp2) begin failures++; $display("[TB] FAIL %s reg2 got %h expected %h", e.name, reg2, e.exp2); end

        do_reset();
        rd = 5'd1; reg_write = 32'h1; write = 1'b1; rs1 = 5'd0; rs2 = 5'd1;
        model[1] = 32'h1;
        push_expect("write_port2", 32'h0, 32'h1);
        @(posedge clk);
        @(negedge clk);
        write = 1'b0;
        e = sb.pop_front();
        assertions += 2;
        if (reg1 !== e.exp1) begin failures++; $display("[TB] FAIL %s reg1 got %h expected %h", e.name, reg1, e.exp1); end
        if (reg2 !== e.exp2) begin failures++; $display("[TB] FAIL %s reg2 got %h expected %h", e.name, reg2, e.exp2); end
    endtask

    // Reset asserted mid-cycle while write stays high: array clears, then the write repeats after reset.
    task automatic test_reset_write_held();
        exp_t e;
        @(negedge clk);
        rd = 5'd1; reg_write = 32'h1; write = 1'b1;
        @(negedge clk);
        rd = 5'd2; reg_write = 32'h1; write = 1'b1; rs1 = 5'd1; rs2 = 5'd2;
        push_expect("held_before_reset", 32'h1, 32'h1);
        @(negedge clk);
        e = sb.pop_front();
        assertions += 2;
        if (reg1 !== e.exp1) begin failures++; $display("[TB] FAIL %s reg1 got %h expected %h", e.name, reg1, e.exp1); end
        if (reg2 !== e.exp2) begin failures++; $display("[TB] FAIL %s reg2 got %h expected %h", e.name, reg2, e.exp2); end
        #2 rst = 1'b1;
        #1;
        push_expect("held_async_clear", 32'h0, 32'h0);
        e = sb.pop_front();
        assertions += 2;
        if (reg1 !== e.exp1) begin failures++; $display("[TB] FAIL %s reg1 got %h expected %h", e.name, reg1, e.exp1); end
        if (reg2 !== e.exp2) begin failures++; $display("[TB] FAIL %s reg2 got %h expected %h", e.name, reg2, e.exp2); end
        @(negedge clk);
        push_expect("held_during_reset", 32'h0, 32'h0);
        e = sb.pop_front();
        assertions += 2;
        if (reg1 !== e.exp1) begin failures++; $display("[TB] FAIL %s reg1 got %h expected %h", e.name, reg1, e.exp1); end
        if (reg2 !== e.exp2) begin failures++; $display("[TB] FAIL %s reg2 got %h expected %h", e.name, reg2, e.exp2); end
        rst = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        model[2] = 32'h1;
        push_expect("held_after_reset", 32'h0, 32'h1);
        @(posedge clk);
        @(negedge clk);
        write = 1'b0;
        e = sb.pop_front();
        assertions += 2;
        if (reg1 !== e.exp1) begin failures++; $display("[TB] FAIL %s reg1 got %h expected %h", e.name, reg1, e.exp1); end
        if (reg2 !== e.exp2) begin failures++; $display("[TB] FAIL %s reg2 got %h expected %h", e.name, reg2, e.exp2); end
    endtask

    // Writes to x0 are discarded on both read ports.
    task automatic test_x0_protect();
        exp_t e;
        @(negedge clk);
        rd = 5'd0; reg_write = 32'hDEAD_BEEF; write = 1'b1; rs1 = 5'd0; rs2 = 5'd0;
        push_expect("x0_protect", 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        write = 1'b0;
        e = sb.pop_front();
        assertions += 2;
        if (reg1 !== e.exp1) begin failures++; $display("[TB] FAIL %s reg1 got %h expected %h", e.name, reg1, e.exp1); end
        if (reg2 !== e.exp2) begin failures++; $display("[TB] FAIL %s reg2 got %h expected %h", e.name, reg2, e.exp2); end
    endtask

    // Disabled write leaves x3 alone; enabled write shows old value before the edge and new value after.
    task automatic test_write_enable_timing();
        exp_t e;
        @(negedge clk);
        rd = 5'd3; reg_write = 32'hA5A5_A5A5; write = 1'b0; rs1 = 5'd3; rs2 = 5'd2;
        push_expect("no_write", 32'h0, model[2]);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        assertions += 2;
        if (reg1 !== e.exp1) begin failures++; $display("[TB] FAIL %s reg1 got %h expected %h", e.name, reg1, e.exp1); end
        if (reg2 !== e.exp2) begin failures++; $display("[TB] FAIL %s reg2 got %h expected %h", e.name, reg2, e.exp2); end
        write = 1'b1;
        #1;
        push_expect("pre_edge_old", 32'h0, model[2]);
        e = sb.pop_front();
        assertions += 2;
        if (reg1 !== e.exp1) begin failures++; $display("[TB] FAIL %s reg1 got %h expected %h", e.name, reg1, e.exp1); end
        if (reg2 !== e.exp2) begin failures++; $display("[TB] FAIL %s reg2 got %h expected %h", e.name, reg2, e.exp2); end
        model[3] = 32'hA5A5_A5A5;
        push_expect("post_edge_new", 32'hA5A5_A5A5, model[2]);
        @(posedge clk);
        #1;
        write = 1'b0;
        e = sb.pop_front();
        assertions += 2;
        if (reg1 !== e.exp1) begin failures++; $display("[TB] FAIL %s reg1 got %h expected %h", e.name, reg1, e.exp1); end
        if (reg2 !== e.exp2) begin failures++; $display("[TB] FAIL %s reg2 got %h expected %h", e.name, reg2, e.exp2); end
    endtask

    // Back-to-back writes to every register, then read pairs changed mid-cycle, including both ports on one register.
    task automatic test_back_to_back();
        exp_t        e;
        logic [31:0] d;
        logic [4:0]  a;
        logic [4:0]  b;
        for (int r = 1; r < 32; r++) begin
            @(negedge clk);
            d = $urandom;
            rd = r[4:0]; reg_write = d; write = 1'b1;
            model[r] = d;
        end
        @(negedge clk);
        write = 1'b0;
        for (int k = 0; k < 40; k++) begin
            a = $urandom_range(0, 31);
            b = (k % 4 == 0) ? a : 5'($urandom_range(0, 31));
            rs1 = a;
            rs2 = b;
            push_expect("b2b_read", model[a], model[b]);
            #1;
            e = sb.pop_front();
            assertions += 2;
            if (reg1 !== e.exp1) begin failures++; $display("[TB] FAIL %s rs1=%0d reg1 got %h expected %h", e.name, a, reg1, e.exp1); end
            if (reg2 !== e.exp2) begin failures++; $display("[TB] FAIL %s rs2=%0d reg2 got %h expected %h", e.name, b, reg2, e.exp2); end
        end
        assertions++;
        if (sb.size() != 0) begin failures++; $display("[TB] FAIL scoreboard_drain got %0d expected 0", sb.size()); end
    endtask

    initial begin
        reg_write = '0;
        write     = 1'b0;
        rd        = '0;
        rs1       = '0;
        rs2       = '0;
        rst       = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = '0;
        test_reset();
        test_write_ports();
        test_reset_write_held();
        test_x0_protect();
        test_write_enable_timing();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
